btn_sw_in: RTL

BTN_SW_IN -- requirements
Module: btn_sw_in

---
 rtl/btn_sw_in.sv | 138 +++++++++++++
 1 files changed

// File: rtl/btn_sw_in.sv
// rtl/btn_sw_in.sv - debounced slide-switch / push-button input block with read port
//
// Synchronises and debounces N_SW switches and N_BTN buttons. It keeps a sticky
// per-button EVENT register and a 32-bit PRESS_COUNT, and exposes them through a
// single-cycle read strobe.
//
// Optional feature macro: BTN_SW_IN_IRQ_EN
//   defined   -> irq is a registered OR of the EVENT bits
//   undefined -> irq is tied low and no interrupt logic is built
//
// Parameters:
//   DEBOUNCE_CYCLES  clk cycles between debounce sample ticks (2..2^24)
//   N_SW             number of slide switches (1..32)
//   N_BTN            number of push buttons (1..16)
//
// Ports:
//   clk      system clock, all state on rising edge
//   rst      asynchronous active-high reset
//   sw       raw asynchronous switch levels
//   btn      raw asynchronous button levels, 1 = pressed
//   rd_en    read strobe, one cycle per read
//   rd_addr  register select: 0 sw, 1 btn, 2 EVENT (clear on read), 3 PRESS_COUNT
//   rd_data  registered read data, valid the cycle after rd_en
//   irq      level interrupt
module btn_sw_in #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int N_SW            = 16,
    parameter int N_BTN           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw,
    input  logic [N_BTN-1:0] btn,
    input  logic             rd_en,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic             irq
);

    localparam int NB = N_SW + N_BTN;
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Switches occupy the low bits and buttons the high bits of every per-bit vector.
    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    hist0;
    logic [NB-1:0]    hist1;
    logic [NB-1:0]    hist2;
    logic [NB-1:0]    db;
    logic [NB-1:0]    db_next;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [N_BTN-1:0] db_btn;
    logic [N_SW-1:0]  db_sw;
    logic [N_BTN-1:0] rise_btn;
    logic [N_BTN-1:0] evt;
    logic             evt_clr;
    logic [31:0]      press_count;
    logic [31:0]      press_inc;

    assign raw    = {btn, sw};
    assign db_sw  = db[N_SW-1:0];
    assign db_btn = db[NB-1:N_SW];
    assign tick   = (cnt == CNT_MAX);

    // A bit goes high only when all three samples are 1 and goes low only when all
    // three samples are 0. Any mixed history leaves the bit unchanged.
    assign db_next  = (db | (hist0 & hist1 & hist2)) & (hist0 | hist1 | hist2);
    assign rise_btn = db_next[NB-1:N_SW] & ~db_btn;

    // Only the bits returned by this read are cleared. Because EVENT is read in
    // full, that is every bit that is currently set.
    assign evt_clr  = rd_en && (rd_addr == 2'd2);

    always_comb begin
        press_inc = 32'd0;
        for (int i = 0; i < N_BTN; i++) begin
            press_inc = press_inc + {31'd0, rise_btn[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt   <= '0;
            hist0 <= '0;
            hist1 <= '0;
            hist2 <= '0;
            db    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                hist0 <= sync2;
                hist1 <= hist0;
                hist2 <= hist1;
            end
            db <= db_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt         <= '0;
            press_count <= 32'd0;
            rd_data     <= 32'd0;
        end else begin
            // A new rise in the read cycle is ORed in after the clear, so set wins.
            evt         <= (evt_clr ? '0 : evt) | rise_btn;
            press_count <= press_count + press_inc;
            if (rd_en) begin
                case (rd_addr)
                    2'd0:    rd_data <= 32'(db_sw);
                    2'd1:    rd_data <= 32'(db_btn);
                    2'd2:    rd_data <= 32'(evt);
                    default: rd_data <= press_count;
                endcase
            end
        end
    end

`ifdef BTN_SW_IN_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule
